// File: rtl/vlsu_axi_addr_gen_if.sv
// rtl/vlsu_axi_addr_gen_if.sv - meta beat handshake plus AXI AR/AW address channels
//
// Purpose: bundles the per-transaction meta handshake from the fragmenter and
// the two AXI address channels driven by vlsu_axi_addr_gen.
// Ports (signals):
//   meta_*      : meta beat from the fragmenter (valid/ready + payload)
//   ar_* / aw_* : AXI4 read / write address channels
// Modports:
//   slave  : address generator view (consumes meta, drives AR/AW)
//   master : environment view (drives meta, consumes AR/AW)
interface vlsu_axi_addr_gen_if #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned IdWidth     = 4,
    parameter int unsigned TxnCntWidth = 8
);
    logic                   meta_valid_i;
    logic                   meta_ready_o;
    logic                   meta_is_load_i;
    logic [AddrWidth-1:0]   meta_seg_base_addr_i;
    logic [TxnCntWidth-1:0] meta_txn_cnt_i;
    logic [TxnCntWidth-1:0] meta_txn_num_i;
    logic [13:0]            meta_ltn_i;
    logic [IdWidth-1:0]     meta_req_id_i;

    logic                   ar_valid_o;
    logic                   ar_ready_i;
    logic [AddrWidth-2:0]   ar_addr_o;
    logic [7:0]             ar_len_o;
    logic [2:0]             ar_size_o;
    logic [1:0]             ar_burst_o;
    logic [IdWidth-1:0]     ar_id_o;

    logic                   aw_valid_o;
    logic                   aw_ready_i;
    logic [AddrWidth-2:0]   aw_addr_o;
    logic [7:0]             aw_len_o;
    logic [2:0]             aw_size_o;
    logic [1:0]             aw_burst_o;
    logic [IdWidth-1:0]     aw_id_o;

    modport slave (
        input  meta_valid_i, meta_is_load_i, meta_seg_base_addr_i, meta_txn_cnt_i,
               meta_txn_num_i, meta_ltn_i, meta_req_id_i,
        output meta_ready_o,
        output ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o,
        input  ar_ready_i,
        output aw_valid_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o, aw_id_o,
        input  aw_ready_i
    );

    modport master (
        output meta_valid_i, meta_is_load_i, meta_seg_base_addr_i, meta_txn_cnt_i,
               meta_txn_num_i, meta_ltn_i, meta_req_id_i,
        input  meta_ready_o,
        input  ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o,
        output ar_ready_i,
        input  aw_valid_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o, aw_id_o,
        output aw_ready_i
    );
endinterface

// File: rtl/vlsu_axi_addr_gen.sv
// rtl/vlsu_axi_addr_gen.sv - page-bounded AXI AR/AW request generator with outstanding throttle
//
// Purpose: turns one meta beat (segment base, txn index/count, last-txn nibble
// end) into one AXI4 INCR address request held in a single issue slot, and
// throttles the fragmenter by counting accepted-but-uncompleted transactions.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   bus             : meta handshake in, AR/AW channels out (slave modport)
//   r_last_done_i   : read transaction completed (rlast beat accepted)
//   b_done_i        : write transaction completed (B accepted)
//   outstanding_o   : accepted, uncompleted transaction count
//   idle_o          : slot empty and nothing outstanding
module vlsu_axi_addr_gen #(
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned AxiDataWidth   = 256,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned TxnCntWidth    = 8,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    vlsu_axi_addr_gen_if.slave                bus,
    input  logic                              r_last_done_i,
    input  logic                              b_done_i,
    output logic [$clog2(MaxOutstanding):0]   outstanding_o,
    output logic                              idle_o
);
    localparam int unsigned W   = AddrWidth + 1;
    localparam int unsigned Bpb = AxiDataWidth / 8;
    localparam int unsigned S   = $clog2(Bpb);
    localparam int unsigned OW  = $clog2(MaxOutstanding) + 1;

    // Issue slot
    logic                  r_valid;
    logic                  r_is_load;
    logic [AddrWidth-2:0]  r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [IdWidth-1:0]    r_id;
    logic [OW-1:0]         r_outstanding;

    // Request computation (nibble domain, W bits wide)
    logic [W-1:0]          w_pgn;
    logic [W-1:0]          w_start;
    logic [W-1:0]          w_end;
    logic [W-1:0]          w_sb;
    logic [W-1:0]          w_eb;
    logic [7:0]            w_len;
    logic [AddrWidth-2:0]  w_addr;

    logic                  w_fire;
    logic                  w_accept;
    logic                  w_meta_ready;
    logic [1:0]            w_dec;
    logic [OW:0]           w_sum;
    logic                  w_underflow;
    logic [OW-1:0]         w_out_nxt;

    always_comb begin
        // Page of this transaction: segment page advanced by the txn index.
        w_pgn   = W'(bus.meta_seg_base_addr_i >> 13) + W'(bus.meta_txn_cnt_i);
        w_start = (bus.meta_txn_cnt_i == '0) ? W'(bus.meta_seg_base_addr_i) : (w_pgn << 13);
        w_end   = (bus.meta_txn_cnt_i == bus.meta_txn_num_i) ? ((w_pgn << 13) + W'(bus.meta_ltn_i))
                                                             : ((w_pgn + W'(1)) << 13);
        w_sb    = w_start >> 1;
        // Exclusive end rounded up to a whole byte.
        w_eb    = (w_end + W'(1)) >> 1;
        // beats = ceil(eb/Bpb) - floor(sb/Bpb); one page never exceeds 256 beats.
        w_len   = 8'(((w_eb + W'(Bpb - 1)) >> S) - (w_sb >> S) - W'(1));
        w_addr  = (AddrWidth-1)'(w_sb & ~W'(Bpb - 1));
    end

    always_comb begin
        w_fire       = r_valid & (r_is_load ? bus.ar_ready_i : bus.aw_ready_i);
        // Throttle looks at the registered count only; same-cycle completions
        // free a credit one cycle later.
        w_meta_ready = (~r_valid | w_fire) & (r_outstanding < OW'(MaxOutstanding));
        w_accept     = bus.meta_valid_i & w_meta_ready;

        w_dec        = {1'b0, r_last_done_i} + {1'b0, b_done_i};
        w_sum        = {1'b0, r_outstanding} + {{OW{1'b0}}, w_accept};
        w_underflow  = w_sum < {{(OW-1){1'b0}}, w_dec};
        w_out_nxt    = w_underflow ? '0 : OW'(w_sum - {{(OW-1){1'b0}}, w_dec});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid       <= 1'b0;
            r_is_load     <= 1'b0;
            r_addr        <= '0;
            r_len         <= '0;
            r_size        <= '0;
            r_burst       <= '0;
            r_id          <= '0;
            r_outstanding <= '0;
        end else begin
            r_outstanding <= w_out_nxt;
            if (w_accept) begin
                r_valid   <= 1'b1;
                r_is_load <= bus.meta_is_load_i;
                r_addr    <= w_addr;
                r_len     <= w_len;
                r_size    <= 3'(S);
                r_burst   <= 2'b01;
                r_id      <= bus.meta_req_id_i;
            end else if (w_fire) begin
                r_valid   <= 1'b0;
            end
        end
    end

    assign bus.meta_ready_o = w_meta_ready;

    assign bus.ar_valid_o   = r_valid & r_is_load;
    assign bus.ar_addr_o    = r_addr;
    assign bus.ar_len_o     = r_len;
    assign bus.ar_size_o    = r_size;
    assign bus.ar_burst_o   = r_burst;
    assign bus.ar_id_o      = r_id;

    assign bus.aw_valid_o   = r_valid & ~r_is_load;
    assign bus.aw_addr_o    = r_addr;
    assign bus.aw_len_o     = r_len;
    assign bus.aw_size_o    = r_size;
    assign bus.aw_burst_o   = r_burst;
    assign bus.aw_id_o      = r_id;

    assign outstanding_o    = r_outstanding;
    assign idle_o           = ~r_valid & (r_outstanding == '0);

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !w_underflow);
    a_txn_order:    assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     w_accept |-> (bus.meta_txn_cnt_i <= bus.meta_txn_num_i));
    a_ltn_range:    assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     w_accept |-> ((bus.meta_ltn_i != '0) && (bus.meta_ltn_i <= 14'd8192)));
endmodule

// File: tb/tb_vlsu_axi_addr_gen.sv
// tb/tb_vlsu_axi_addr_gen.sv - directed self-checking bench for vlsu_axi_addr_gen
module tb_vlsu_axi_addr_gen;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       r_last_done_i;
    logic       b_done_i;
    logic [3:0] outstanding_o;
    logic       idle_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    vlsu_axi_addr_gen_if #(.AddrWidth(64), .IdWidth(4), .TxnCntWidth(8)) bus ();

    vlsu_axi_addr_gen #(
        .AddrWidth(64), .AxiDataWidth(256), .IdWidth(4), .TxnCntWidth(8), .MaxOutstanding(8)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .bus           (bus),
        .r_last_done_i (r_last_done_i),
        .b_done_i      (b_done_i),
        .outstanding_o (outstanding_o),
        .idle_o        (idle_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic meta(input logic ld, input logic [63:0] seg, input logic [7:0] cnt,
                        input logic [7:0] num, input logic [13:0] ltn, input logic [3:0] id);
        bus.meta_valid_i         = 1'b1;
        bus.meta_is_load_i       = ld;
        bus.meta_seg_base_addr_i = seg;
        bus.meta_txn_cnt_i       = cnt;
        bus.meta_txn_num_i       = num;
        bus.meta_ltn_i           = ltn;
        bus.meta_req_id_i        = id;
    endtask

    initial begin
        rst_ni                   = 1'b0;
        r_last_done_i            = 1'b0;
        b_done_i                 = 1'b0;
        bus.meta_valid_i         = 1'b0;
        bus.meta_is_load_i       = 1'b0;
        bus.meta_seg_base_addr_i = '0;
        bus.meta_txn_cnt_i       = '0;
        bus.meta_txn_num_i       = '0;
        bus.meta_ltn_i           = 14'd1;
        bus.meta_req_id_i        = '0;
        bus.ar_ready_i           = 1'b0;
        bus.aw_ready_i           = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_ar_valid", 64'(bus.ar_valid_o), 64'd0);
        chk("rst_aw_valid", 64'(bus.aw_valid_o), 64'd0);
        chk("rst_ar_addr", 64'(bus.ar_addr_o), 64'd0);
        chk("rst_ar_len", 64'(bus.ar_len_o), 64'd0);
        chk("rst_ar_size", 64'(bus.ar_size_o), 64'd0);
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_idle", 64'(idle_o), 64'd1);
        chk("rst_meta_ready", 64'(bus.meta_ready_o), 64'd1);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Single read: 0x100 .. 0x180 nibbles -> bytes 0x80..0xC0, two 32B beats
        meta(1'b1, 64'h100, 8'd0, 8'd0, 14'h180, 4'd5);
        chk("t1_meta_ready", 64'(bus.meta_ready_o), 64'd1);
        @(negedge clk_i);
        bus.meta_valid_i = 1'b0;
        chk("t1_ar_valid", 64'(bus.ar_valid_o), 64'd1);
        chk("t1_aw_valid", 64'(bus.aw_valid_o), 64'd0);
        chk("t1_ar_addr", 64'(bus.ar_addr_o), 64'h80);
        chk("t1_ar_len", 64'(bus.ar_len_o), 64'd1);
        chk("t1_ar_size", 64'(bus.ar_size_o), 64'd5);
        chk("t1_ar_burst", 64'(bus.ar_burst_o), 64'd1);
        chk("t1_ar_id", 64'(bus.ar_id_o), 64'd5);
        chk("t1_outstanding", 64'(outstanding_o), 64'd1);
        chk("t1_idle", 64'(idle_o), 64'd0);
        bus.ar_ready_i = 1'b1;
        @(negedge clk_i);
        chk("t1_ar_valid_drop", 64'(bus.ar_valid_o), 64'd0);
        r_last_done_i = 1'b1;
        @(negedge clk_i);
        r_last_done_i = 1'b0;
        chk("t1_outstanding_ret", 64'(outstanding_o), 64'd0);
        chk("t1_idle_ret", 64'(idle_o), 64'd1);

        // Page-crossing store, two transactions back-to-back
        bus.aw_ready_i = 1'b1;
        meta(1'b0, 64'h1F00, 8'd0, 8'd1, 14'h100, 4'd2);
        @(negedge clk_i);
        chk("t2a_aw_valid", 64'(bus.aw_valid_o), 64'd1);
        chk("t2a_ar_valid", 64'(bus.ar_valid_o), 64'd0);
        chk("t2a_aw_addr", 64'(bus.aw_addr_o), 64'hF80);
        chk("t2a_aw_len", 64'(bus.aw_len_o), 64'd3);
        meta(1'b0, 64'h1F00, 8'd1, 8'd1, 14'h100, 4'd2);
        chk("t2_refill_ready", 64'(bus.meta_ready_o), 64'd1);
        @(negedge clk_i);
        bus.meta_valid_i = 1'b0;
        chk("t2b_aw_valid", 64'(bus.aw_valid_o), 64'd1);
        chk("t2b_aw_addr", 64'(bus.aw_addr_o), 64'h1000);
        chk("t2b_aw_len", 64'(bus.aw_len_o), 64'd3);
        @(negedge clk_i);
        chk("t2_aw_valid_drop", 64'(bus.aw_valid_o), 64'd0);
        chk("t2_outstanding", 64'(outstanding_o), 64'd2);
        b_done_i = 1'b1;
        repeat (2) @(negedge clk_i);
        b_done_i = 1'b0;
        chk("t2_outstanding_ret", 64'(outstanding_o), 64'd0);

        // Middle full page, then odd nibble start
        meta(1'b1, 64'h1F00, 8'd1, 8'd2, 14'h100, 4'd7);
        @(negedge clk_i);
        chk("t3_ar_addr", 64'(bus.ar_addr_o), 64'h1000);
        chk("t3_ar_len", 64'(bus.ar_len_o), 64'd127);
        chk("t3_ar_id", 64'(bus.ar_id_o), 64'd7);
        meta(1'b1, 64'h3, 8'd0, 8'd0, 14'h43, 4'd8);
        @(negedge clk_i);
        bus.meta_valid_i = 1'b0;
        chk("t4_ar_valid", 64'(bus.ar_valid_o), 64'd1);
        chk("t4_ar_addr", 64'(bus.ar_addr_o), 64'h0);
        chk("t4_ar_len", 64'(bus.ar_len_o), 64'd1);
        chk("t4_ar_id", 64'(bus.ar_id_o), 64'd8);
        r_last_done_i = 1'b1;
        repeat (2) @(negedge clk_i);
        r_last_done_i = 1'b0;
        chk("t4_outstanding_ret", 64'(outstanding_o), 64'd0);
        chk("t4_idle", 64'(idle_o), 64'd1);

        // Throttle at MaxOutstanding = 8
        meta(1'b1, 64'h100, 8'd0, 8'd0, 14'h180, 4'd1);
        repeat (8) @(negedge clk_i);
        chk("thr_outstanding_full", 64'(outstanding_o), 64'd8);
        chk("thr_meta_ready_low", 64'(bus.meta_ready_o), 64'd0);
        bus.meta_valid_i = 1'b0;
        r_last_done_i    = 1'b1;
        b_done_i         = 1'b1;
        chk("thr_same_cycle_ready", 64'(bus.meta_ready_o), 64'd0);
        @(negedge clk_i);
        r_last_done_i = 1'b0;
        b_done_i      = 1'b0;
        chk("thr_outstanding_6", 64'(outstanding_o), 64'd6);
        chk("thr_meta_ready_back", 64'(bus.meta_ready_o), 64'd1);

        // Stall with ar_ready low, then reset mid-stall
        bus.ar_ready_i = 1'b0;
        meta(1'b1, 64'h100, 8'd0, 8'd0, 14'h180, 4'hA);
        @(negedge clk_i);
        meta(1'b1, 64'h3, 8'd0, 8'd0, 14'h43, 4'd3);
        chk("stall_outstanding", 64'(outstanding_o), 64'd7);
        for (int i = 0; i < 5; i++) begin
            chk("stall_ar_valid", 64'(bus.ar_valid_o), 64'd1);
            chk("stall_ar_addr", 64'(bus.ar_addr_o), 64'h80);
            chk("stall_ar_len", 64'(bus.ar_len_o), 64'd1);
            chk("stall_ar_id", 64'(bus.ar_id_o), 64'hA);
            chk("stall_meta_ready", 64'(bus.meta_ready_o), 64'd0);
            @(negedge clk_i);
        end
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_ar_valid", 64'(bus.ar_valid_o), 64'd0);
        chk("rst_mid_ar_addr", 64'(bus.ar_addr_o), 64'd0);
        chk("rst_mid_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_mid_idle", 64'(idle_o), 64'd1);
        bus.meta_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_idle", 64'(idle_o), 64'd1);
        chk("post_rst_meta_ready", 64'(bus.meta_ready_o), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/vlsu_axi_addr_gen.md
# vlsu_axi_addr_gen

Downstream stage of the VLSU request fragmenter. It consumes one per-transaction meta beat per handshake: segment base address, transaction index and count, and last-transaction nibble count. From that beat it produces a page-bounded AXI4 INCR request on AR for loads or AW for stores. It registers the request in a single issue slot and throttles the fragmenter with an outstanding-transaction counter that is retired by R-last and B completions.

## Interface
- AddrWidth, 64: meta segment base address width, in nibbles; AXI byte address is AddrWidth-1 bits
- AxiDataWidth, 256: AXI data width in bits; legal values are 128, 256, 512; bytes per beat Bpb = AxiDataWidth/8
- IdWidth, 4: AXI ID width
- TxnCntWidth, 8: width of the transaction index and count fields
- MaxOutstanding, 8: maximum accepted, uncompleted transactions; power of two
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- meta_valid_i / meta_ready_o  in/out  1  meta handshake
- meta_is_load_i  in  1  1 = AR, 0 = AW
- meta_seg_base_addr_i  in  AddrWidth  segment base, nibble address
- meta_txn_cnt_i  in  TxnCntWidth  index of this transaction within the segment
- meta_txn_num_i  in  TxnCntWidth  index of the segment's last transaction
- meta_ltn_i  in  14  last-transaction end offset in nibbles from its page base; range 1..8192
- meta_req_id_i  in  IdWidth  AXI ID to use
- ar_valid_o / ar_ready_i, aw_valid_o / aw_ready_i  out/in  1  AXI handshakes
- ar_addr_o, aw_addr_o  out  AddrWidth-1  beat-aligned byte address
- ar_len_o, aw_len_o  out  8; ar_size_o, aw_size_o  out  3; ar_burst_o, aw_burst_o  out  2; ar_id_o, aw_id_o  out  IdWidth
- r_last_done_i  in  1  R beat with rlast accepted
- b_done_i  in  1  B response accepted
- outstanding_o  out  $clog2(MaxOutstanding)+1  current outstanding count
- idle_o  out  1  slot empty and outstanding_o == 0

## Operation
- Page size is 8192 nibbles (4 KiB). pg = seg_base[AddrWidth-1:13].
- Transaction start, in nibbles:
  - txn_cnt == 0: start = seg_base.
  - otherwise: start = (pg + txn_cnt) << 13.
- Transaction end, exclusive, in nibbles:
  - txn_cnt == txn_num: end = ((pg + txn_cnt) << 13) + ltn.
  - otherwise: end = (pg + txn_cnt + 1) << 13.
- Byte bounds:
  - sb = start >> 1.
  - eb = (end + 1) >> 1, i.e. ceil.
- Beat count: beats = ceil(eb/Bpb) - floor(sb/Bpb).
- Request fields:
  - len = beats - 1. Always ≤ 255, because 4096/16 = 256.
  - addr = sb & ~(Bpb-1).
  - size = log2(Bpb).
  - burst = 2'b01 (INCR).
  - id = meta_req_id_i.
- All arithmetic is performed at AddrWidth+1 bits; overflow beyond the address space is not checked.
- Issue slot holds one request: slot_valid, slot_is_load, and the fields above.
  - ar_valid_o = slot_valid & slot_is_load.
  - aw_valid_o = slot_valid & ~slot_is_load.
  - Both channels' field outputs are driven from the slot.
- Throttle:
  - meta_ready_o = (~slot_valid | slot_fire) & (outstanding < MaxOutstanding).
  - A completion in the same cycle does not raise meta_ready_o.
- Outstanding counter:
  - +1 on meta accept.
  - -1 per asserted r_last_done_i and -1 per asserted b_done_i; both may assert in the same cycle.
  - Net change is applied in one cycle.
  - A decrement at 0 holds the counter at 0 and fires an assertion.
- A meta_txn_cnt_i > meta_txn_num_i, or meta_ltn_i outside 1..8192, is illegal and fires an assertion; the output in that case is unspecified.

## Timing
- Reset values:
  - slot_valid = 0, all slot fields = 0.
  - outstanding = 0.
  - Outputs: ar/aw_valid_o = 0, all address-channel fields = 0, outstanding_o = 0, idle_o = 1.
  - meta_ready_o = 1, since it is combinational from reset state.
- Latency: meta accepted at edge N → ar/aw_valid_o high from N+1. outstanding_o increments at N+1.
- Back-to-back: with ready held high, one transaction issues per cycle, up to MaxOutstanding.
- Valid stability: once ar/aw_valid_o asserts, the valid and all fields hold until the ready handshake. The slot refills in the same cycle it fires.
- Reset asserted mid-operation clears the slot and the counter immediately. In-flight AXI responses after reset are the system's responsibility.

## Test plan
- Single read, AxiDataWidth 256, seg_base 0x100, txn_num 0, ltn 0x180 → ar_addr 0x80, len 1, size 5, valid one cycle after accept.
- Page cross, store, seg_base 0x1F00, txn_num 1:
  - txn0 → aw_addr 0xF80, len 3.
  - txn1 with ltn 0x100 → aw_addr 0x1000, len 3.
  - Issued on consecutive cycles with aw_ready held high.
- Middle full page: seg_base 0x1F00, txn_cnt 1, txn_num 2 → addr 0x1000, len 127.
- Odd nibble: seg_base 0x3, txn_num 0, ltn 0x43 → addr 0x0, len 1.
- Throttle, MaxOutstanding 8:
  - Issue 8 reads with no completions → meta_ready_o 0.
  - Assert r_last_done_i and b_done_i together → outstanding 8→6; meta_ready_o returns next cycle.
- Stall and reset: hold ar_ready_i low for 5 cycles → addr, len and id stable, meta_ready_o 0. Assert rst_ni low mid-stall → ar_valid_o 0, outstanding_o 0, idle_o 1.
